seg_display_scan: RTL and testbench

//  Parametrised N-digit multiplexed 7-segment driver for the Basys board display.
//  - Sequential double-dabble converter (one bit per clock): replaces combinational divide/modulo.
//  - Hex mode, leading-zero blanking, overflow indication, programmable refresh rate.
//  - Tear-free update: the display changes atomically on completion.
//  - Sits between the datapath result registers and the board anode/cathode pins.

---
 rtl/seg_pkg.sv | 33 +++
 rtl/seg_display_scan_bcd_dabble.sv | 79 +++++++
 rtl/seg_display_scan.sv | 125 ++++++++++++
 tb/tb_seg_display_scan.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types, glyph constants and the 7-segment encoder for the display scan block.
// Segment vectors are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic {IDLE, SHIFT} conv_state_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_display_scan_bcd_dabble.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// bcd/ovf present the post-shift value so the caller can commit it on the edge busy falls.
module bcd_dabble
  import seg_pkg::*;
#(
  parameter int DIN_W    = 16,
  parameter int N_DIGITS = 4
) (
  input  logic                  disp_clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [N_DIGITS*4-1:0] bcd,
  output logic                  ovf
);

  localparam int BCD_W = N_DIGITS * 4;
  localparam int CNT_W = (DIN_W > 1) ? $clog2(DIN_W) : 1;

  conv_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [DIN_W-1:0] shift_reg;
  logic [BCD_W-1:0] bcd_reg;
  logic [BCD_W-1:0] bcd_adj;
  logic             ovf_reg;
  logic             last_bit;

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  assign last_bit = (cnt_reg == CNT_W'(DIN_W - 1));
  assign busy     = (state_reg == SHIFT);
  assign done     = busy && last_bit;
  // A set top bit after adjustment would be shifted out of the BCD register.
  assign bcd      = {bcd_adj[BCD_W-2:0], shift_reg[DIN_W-1]};
  assign ovf      = ovf_reg | bcd_adj[BCD_W-1];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge disp_clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shift_reg <= '0;
      bcd_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE) begin
        if (start) begin
          shift_reg <= bin;
          bcd_reg   <= '0;
          ovf_reg   <= 1'b0;
          cnt_reg   <= '0;
        end
      end else begin
        shift_reg <= shift_reg << 1;
        bcd_reg   <= bcd;
        ovf_reg   <= ovf;
        cnt_reg   <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_display_scan.sv
// Multiplexed N-digit 7-segment driver: decimal/hex capture, tear-free commit,
// leading-zero blanking, overflow dashes and a prescaled anode scan.
module seg_display_scan
  import seg_pkg::*;
#(
  parameter int DIN_W       = 16,
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 1
) (
  input  logic                disp_clk,
  input  logic                rst_n,
  input  logic [DIN_W-1:0]    din,
  input  logic                load,
  input  logic                hex_mode,
  input  logic                blank_lz,
  output logic                busy,
  output logic                overflow,
  output logic [N_DIGITS-1:0] anodes,
  output logic [6:0]          segment
);

  localparam int DIG_W = 4 * N_DIGITS;
  localparam int EXT_W = (DIN_W > DIG_W) ? DIN_W : DIG_W;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic                capture, dab_start, dab_busy, dab_done, dab_ovf;
  logic [DIG_W-1:0]    dab_bcd;
  logic                hex_busy_reg;
  logic [DIN_W-1:0]    din_reg;
  logic [EXT_W-1:0]    din_ext;
  logic                hex_ovf;
  logic [DIG_W-1:0]    digits_reg;
  logic                ovf_reg;
  logic [PRE_W-1:0]    presc_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [N_DIGITS-1:0] anodes_reg;
  logic [6:0]          segment_reg;
  logic [N_DIGITS-1:0] nz, hi_nz;
  logic                nz_acc;
  logic [6:0]          glyph [N_DIGITS];

  assign busy      = dab_busy | hex_busy_reg;
  assign capture   = load && !busy;
  assign dab_start = capture && !hex_mode;
  assign overflow  = ovf_reg;
  assign anodes    = anodes_reg;
  assign segment   = segment_reg;
  assign din_ext   = EXT_W'(din_reg);

  bcd_dabble #(
    .DIN_W    (DIN_W),
    .N_DIGITS (N_DIGITS)
  ) u_dabble (
    .disp_clk (disp_clk),
    .rst_n    (rst_n),
    .start    (dab_start),
    .bin      (din),
    .busy     (dab_busy),
    .done     (dab_done),
    .bcd      (dab_bcd),
    .ovf      (dab_ovf)
  );

  genvar gi;
  generate
    if (DIN_W > DIG_W) begin : g_hex_ovf
      assign hex_ovf = |din_ext[EXT_W-1:DIG_W];
    end else begin : g_hex_fits
      assign hex_ovf = 1'b0;
    end

    for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      assign nz[gi]    = |digits_reg[gi*4 +: 4];
      assign glyph[gi] = ovf_reg ? SEG_DASH :
                         (blank_lz && (gi != 0) && !hi_nz[gi]) ? SEG_BLANK :
                         seg_encode(digits_reg[gi*4 +: 4]);
    end
  endgenerate

  // hi_nz[k]: some digit at position k or above is nonzero.
  always_comb begin
    nz_acc = 1'b0;
    hi_nz  = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      nz_acc   = nz_acc | nz[k];
      hi_nz[k] = nz_acc;
    end
  end

  always_ff @(posedge disp_clk) begin
    if (!rst_n) begin
      hex_busy_reg <= 1'b0;
      din_reg      <= '0;
      digits_reg   <= '0;
      ovf_reg      <= 1'b0;
      presc_reg    <= '0;
      idx_reg      <= '0;
      anodes_reg   <= '1;
      segment_reg  <= SEG_BLANK;
    end else begin
      hex_busy_reg <= capture && hex_mode;
      if (capture) din_reg <= din;

      if (dab_done) begin
        digits_reg <= dab_bcd;
        ovf_reg    <= dab_ovf;
      end else if (hex_busy_reg) begin
        digits_reg <= din_ext[DIG_W-1:0];
        ovf_reg    <= hex_ovf;
      end

      // Anode and cathode come from the same index so they never skew.
      anodes_reg  <= ~(N_DIGITS'(1) << idx_reg);
      segment_reg <= glyph[idx_reg];
      if (presc_reg == PRE_W'(REFRESH_DIV - 1)) begin
        presc_reg <= '0;
        idx_reg   <= (idx_reg == IDX_W'(N_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
      end else begin
        presc_reg <= presc_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan: a 4-digit instance plus a 6-digit, divide-by-3 instance.
module tb_seg_display_scan;

  logic        clk = 1'b0;
  logic        rst_n, load, hex_mode, blank_lz;
  logic [15:0] din;
  logic        busy, overflow;
  logic [3:0]  anodes;
  logic [6:0]  segment;
  logic        busy6, overflow6;
  logic [5:0]  anodes6;
  logic [6:0]  segment6;

  int errors = 0;
  int checks = 0;
  logic [6:0] disp [4];

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                         G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                         G9 = 7'b0010000, GA = 7'b0001000, GF = 7'b0001110,
                         BL = 7'h7F,      DASH = 7'b0111111;

  always #5 clk = ~clk;

  seg_display_scan #(.DIN_W(16), .N_DIGITS(4), .REFRESH_DIV(1)) dut (
    .disp_clk (clk), .rst_n (rst_n), .din (din), .load (load),
    .hex_mode (hex_mode), .blank_lz (blank_lz), .busy (busy),
    .overflow (overflow), .anodes (anodes), .segment (segment)
  );

  seg_display_scan #(.DIN_W(16), .N_DIGITS(6), .REFRESH_DIV(3)) dut6 (
    .disp_clk (clk), .rst_n (rst_n), .din (din), .load (load),
    .hex_mode (hex_mode), .blank_lz (blank_lz), .busy (busy6),
    .overflow (overflow6), .anodes (anodes6), .segment (segment6)
  );

  // Collect one full scan of the 4-digit display; unseen digits stay X.
  task automatic read_display();
    logic [3:0] mask;
    for (int k = 0; k < 4; k++) disp[k] = 7'bx;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        mask = 4'b0001 << k;
        if (anodes == ~mask) disp[k] = segment;
      end
    end
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic hx);
    din = v; hex_mode = hx; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Count busy-high cycles from the negedge after the capture edge (bounded).
  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; din = '0; hex_mode = 1'b0; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (anodes !== 4'hF) begin errors++; $display("FAIL reset_anodes got=%h exp=f", anodes); end
    checks++; if (segment !== BL) begin errors++; $display("FAIL reset_segment got=%h exp=%h", segment, BL); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (anodes6 !== 6'h3F) begin errors++; $display("FAIL reset_anodes6 got=%h exp=3f", anodes6); end
    rst_n = 1'b1;
    read_display();
    for (int k = 0; k < 4; k++) begin
      checks++; if (disp[k] !== G0) begin errors++; $display("FAIL reset_digit%0d got=%b exp=%b", k, disp[k], G0); end
    end
    blank_lz = 1'b1;
    read_display();
    checks++; if (disp[0] !== G0) begin errors++; $display("FAIL reset_blank_d0 got=%b exp=%b", disp[0], G0); end
    for (int k = 1; k < 4; k++) begin
      checks++; if (disp[k] !== BL) begin errors++; $display("FAIL reset_blank_d%0d got=%b exp=%b", k, disp[k], BL); end
    end
    blank_lz = 1'b0;
    $display("reset: released, display 0000 / blanked '   0'");
  endtask

  task automatic test_decimal();
    int n;
    logic [6:0] exp_g [4];
    exp_g = '{G4, G3, G2, G1};
    pulse_load(16'd1234, 1'b0);
    wait_busy(n);
    checks++; if (n != 16) begin errors++; $display("FAIL dec_busy_cycles got=%0d exp=16", n); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL dec_overflow got=%b exp=0", overflow); end
    read_display();
    for (int k = 0; k < 4; k++) begin
      checks++; if (disp[k] !== exp_g[k]) begin errors++; $display("FAIL dec_digit%0d got=%b exp=%b", k, disp[k], exp_g[k]); end
    end
    $display("load dec 1234: busy %0d cycles", n);
  endtask

  task automatic test_overflow();
    int n;
    pulse_load(16'd10000, 1'b0);
    wait_busy(n);
    checks++; if (n != 16) begin errors++; $display("FAIL ovf_busy_cycles got=%0d exp=16", n); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    blank_lz = 1'b1;
    read_display();
    for (int k = 0; k < 4; k++) begin
      checks++; if (disp[k] !== DASH) begin errors++; $display("FAIL ovf_digit%0d got=%b exp=%b", k, disp[k], DASH); end
    end
    blank_lz = 1'b0;
    $display("load dec 10000: overflow=%b", overflow);
    pulse_load(16'd9999, 1'b0);
    wait_busy(n);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    read_display();
    for (int k = 0; k < 4; k++) begin
      checks++; if (disp[k] !== G9) begin errors++; $display("FAIL d9999_digit%0d got=%b exp=%b", k, disp[k], G9); end
    end
    $display("load dec 9999: overflow=%b", overflow);
  endtask

  task automatic test_hex_blank();
    int n;
    logic [6:0] exp_g [4];
    exp_g = '{GF, GA, BL, BL};
    blank_lz = 1'b1;
    pulse_load(16'h00AF, 1'b1);
    wait_busy(n);
    checks++; if (n != 1) begin errors++; $display("FAIL hex_busy_cycles got=%0d exp=1", n); end
    read_display();
    for (int k = 0; k < 4; k++) begin
      checks++; if (disp[k] !== exp_g[k]) begin errors++; $display("FAIL hex_digit%0d got=%b exp=%b", k, disp[k], exp_g[k]); end
    end
    hex_mode = 1'b0; blank_lz = 1'b0;
    $display("load hex 00AF: busy %0d cycles", n);
  endtask

  // Load arriving on the edge busy falls must be dropped.
  task automatic test_back_to_back();
    logic [6:0] exp_g [4];
    exp_g = '{G4, G3, G2, G1};
    pulse_load(16'd1234, 1'b0);
    repeat (15) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_last_busy got=%b exp=1", busy); end
    din = 16'd9999; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_dropped got=%b exp=0", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", busy); end
    read_display();
    for (int k = 0; k < 4; k++) begin
      checks++; if (disp[k] !== exp_g[k]) begin errors++; $display("FAIL b2b_digit%0d got=%b exp=%b", k, disp[k], exp_g[k]); end
    end
    $display("load at busy-fall edge: dropped, display 1234");
  endtask

  task automatic test_busy_reset();
    int n;
    logic seen5;
    logic [6:0] exp_g [4];
    exp_g = '{G2, G4, G0, G0};
    pulse_load(16'd42, 1'b0);
    din = 16'd77; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_busy(n);
    checks++; if (n != 15) begin errors++; $display("FAIL busy_drop_cycles got=%0d exp=15", n); end
    read_display();
    for (int k = 0; k < 4; k++) begin
      checks++; if (disp[k] !== exp_g[k]) begin errors++; $display("FAIL busy_drop_digit%0d got=%b exp=%b", k, disp[k], exp_g[k]); end
    end
    $display("load 42 then 77 while busy: display 0042");
    pulse_load(16'd55, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    seen5 = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (segment === G5 || busy !== 1'b0) seen5 = 1'b1;
    end
    checks++; if (seen5 !== 1'b0) begin errors++; $display("FAIL abort_no_55 got=%b exp=0", seen5); end
    read_display();
    for (int k = 0; k < 4; k++) begin
      checks++; if (disp[k] !== G0) begin errors++; $display("FAIL abort_digit%0d got=%b exp=%b", k, disp[k], G0); end
    end
    $display("load 55 aborted by reset: display 0000");
  endtask

  task automatic test_refresh();
    int n, run;
    int kk [36];
    logic [5:0] an [36];
    logic [6:0] sg [36];
    logic [5:0] mask;
    logic [6:0] exp6 [6];
    exp6 = '{G1, G2, G3, G4, G5, G0};
    pulse_load(16'd54321, 1'b0);
    n = 0;
    while (busy6 && n < 100) begin n++; @(negedge clk); end
    checks++; if (n != 16) begin errors++; $display("FAIL ref_busy_cycles got=%0d exp=16", n); end
    checks++; if (overflow6 !== 1'b0) begin errors++; $display("FAIL ref_overflow got=%b exp=0", overflow6); end
    repeat (2) @(negedge clk);
    for (int t = 0; t < 36; t++) begin
      an[t] = anodes6; sg[t] = segment6; kk[t] = -1;
      for (int k = 0; k < 6; k++) begin
        mask = 6'b000001 << k;
        if (an[t] == ~mask) kk[t] = k;
      end
      checks++;
      if (kk[t] < 0 || sg[t] !== exp6[(kk[t] < 0) ? 0 : kk[t]]) begin
        errors++; $display("FAIL ref_align t=%0d anodes=%b seg=%b", t, an[t], sg[t]);
      end
      @(negedge clk);
    end
    for (int t = 0; t < 18; t++) begin
      checks++; if (an[t] !== an[t+18]) begin errors++; $display("FAIL ref_period t=%0d got=%b exp=%b", t, an[t+18], an[t]); end
    end
    run = 1;
    for (int t = 1; t < 36; t++) begin
      if (kk[t] == kk[t-1]) run++;
      else begin
        if (run != 1 || t > 3) begin
          if (t > 3 || run == 3) begin
            checks++; if (run != 3 && t > 3) begin errors++; $display("FAIL ref_dwell t=%0d got=%0d exp=3", t, run); end
          end
        end
        checks++; if (kk[t] != (kk[t-1] + 1) % 6) begin errors++; $display("FAIL ref_order t=%0d got=%0d exp=%0d", t, kk[t], (kk[t-1] + 1) % 6); end
        run = 1;
      end
    end
    $display("refresh 6 digits / div 3: 36 cycles scanned");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; load = 1'b0; din = '0; hex_mode = 1'b0; blank_lz = 1'b0;
    test_reset();
    test_decimal();
    test_overflow();
    test_hex_blank();
    test_back_to_back();
    test_busy_reset();
    test_refresh();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
